bitonic_sort_pipe: RTL and testbench



---
 rtl/bitonic_pkg.sv | 32 +++
 rtl/bsn_cas_cell.sv | 20 ++
 rtl/bitonic_sort_pipe.sv | 72 +++++++
 tb/tb_bitonic_sort_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bitonic_pkg.sv
// bitonic_pkg: stage schedule and lane helpers for the bitonic sorting network.
package bitonic_pkg;
   localparam int MAX_LOG2_N = 6;
   function automatic int num_stages(input int log2n);
      return log2n * (log2n + 1) / 2;
   endfunction
   // The column order of a small network is a prefix of the largest one,
   // so the stage-to-(k,j) mapping does not depend on N.
   function automatic int stage_k(input int s);
      int n = 0;
      int r = 0;
      for (int lk = 1; lk <= MAX_LOG2_N; lk++)
         for (int lj = lk - 1; lj >= 0; lj--) begin
            if (n == s) r = 1 << lk;
            n++;
         end
      return r;
   endfunction
   function automatic int stage_j(input int s);
      int n = 0;
      int r = 0;
      for (int lk = 1; lk <= MAX_LOG2_N; lk++)
         for (int lj = lk - 1; lj >= 0; lj--) begin
            if (n == s) r = 1 << lj;
            n++;
         end
      return r;
   endfunction
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction
endpackage

// File: rtl/bsn_cas_cell.sv
// bsn_cas_cell: combinational compare-exchange; equal keys pass unchanged.
module bsn_cas_cell #(
   parameter int DATA_WIDTH = 32,
   parameter int SIGNED = 0
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  up,
   output logic [DATA_WIDTH-1:0] lo_pos,
   output logic [DATA_WIDTH-1:0] hi_pos
);
   logic a_lt_b, b_lt_a, swap;
   always_comb begin
      a_lt_b = SIGNED != 0 ? $signed(a) < $signed(b) : a < b;
      b_lt_a = SIGNED != 0 ? $signed(b) < $signed(a) : b < a;
      swap = up ? b_lt_a : a_lt_b;
      lo_pos = swap ? b : a;
      hi_pos = swap ? a : b;
   end
endmodule

// File: rtl/bitonic_sort_pipe.sv
// bitonic_sort_pipe: fully pipelined bitonic sorter, one register stage per
// compare-exchange column, with a global stall driven by the output handshake.
module bitonic_sort_pipe
   import bitonic_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LOG2_N = 3,
   parameter int SIGNED = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             in_dir,
   input  logic [(1<<LOG2_N)*DATA_WIDTH-1:0] in_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             out_dir,
   output logic [(1<<LOG2_N)*DATA_WIDTH-1:0] out_data
);
   localparam int N = 1 << LOG2_N;
   localparam int W = N * DATA_WIDTH;
   localparam int S = num_stages(LOG2_N);

   logic [S-1:0][W-1:0] q_d, src, nxt;
   logic [S-1:0]        q_v, q_dir, src_v, src_dir;
   logic                adv;

   assign adv = !q_v[S-1] | out_ready;
   assign in_ready = adv & !rst;
   assign out_valid = q_v[S-1];
   assign out_data = q_d[S-1];
   assign out_dir = q_dir[S-1];

   genvar s, i;
   for (s = 0; s < S; s++) begin : g_stage
      localparam int K = stage_k(s);
      localparam int J = stage_j(s);
      if (s == 0) begin : g_in
         assign src[s] = in_data;
         assign src_v[s] = in_valid & in_ready;
         assign src_dir[s] = in_dir;
      end else begin : g_mid
         assign src[s] = q_d[s-1];
         assign src_v[s] = q_v[s-1];
         assign src_dir[s] = q_dir[s-1];
      end
      for (i = 0; i < N; i++) begin : g_lane
         if ((i ^ J) > i) begin : g_cas
            localparam int P = i ^ J;
            bsn_cas_cell #(.DATA_WIDTH(DATA_WIDTH), .SIGNED(SIGNED)) u_cas (
               .a(src[s][lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
               .b(src[s][lane_lsb(P, DATA_WIDTH) +: DATA_WIDTH]),
               .up(((i & K) == 0) ^ src_dir[s]),
               .lo_pos(nxt[s][lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
               .hi_pos(nxt[s][lane_lsb(P, DATA_WIDTH) +: DATA_WIDTH])
            );
         end
      end
   end

   always_ff @(posedge clk)
      if (rst) begin
         q_d <= '0;
         q_v <= '0;
         q_dir <= '0;
      end else if (adv) begin
         q_d <= nxt;
         q_v <= src_v;
         q_dir <= src_dir;
      end
endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// tb_bitonic_sort_pipe: directed and scoreboard checks across four sorter builds.
module tb_bitonic_sort_pipe;
   logic clk = 0, rst = 1, in_valid = 0, in_dir = 0, out_ready = 1;
   logic [255:0] d8 = '0;
   logic [127:0] d16 = '0;
   logic [15:0]  d2 = '0;
   logic r0, v0, od0, r1, v1, od1, r2, v2, od2, r3, v3, od3;
   logic [255:0] o0, o1;
   logic [127:0] o2;
   logic [15:0]  o3;
   int n_cmp = 0, n_err = 0;
   bit sb_en = 0;
   logic [256:0] sb_q[$];
   int lat0, lat2, lat3;
   logic [255:0] c0, c1;
   logic [127:0] c2;
   logic [15:0]  c3;
   logic cd0, cd2, cd3;

   always #5 clk = ~clk;

   bitonic_sort_pipe #(.DATA_WIDTH(32), .LOG2_N(3), .SIGNED(0)) u0 (.clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(r0), .in_dir(in_dir), .in_data(d8),
      .out_valid(v0), .out_ready(out_ready), .out_dir(od0), .out_data(o0));
   bitonic_sort_pipe #(.DATA_WIDTH(32), .LOG2_N(3), .SIGNED(1)) u1 (.clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(r1), .in_dir(in_dir), .in_data(d8),
      .out_valid(v1), .out_ready(out_ready), .out_dir(od1), .out_data(o1));
   bitonic_sort_pipe #(.DATA_WIDTH(8), .LOG2_N(4), .SIGNED(0)) u2 (.clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(r2), .in_dir(in_dir), .in_data(d16),
      .out_valid(v2), .out_ready(out_ready), .out_dir(od2), .out_data(o2));
   bitonic_sort_pipe #(.DATA_WIDTH(8), .LOG2_N(1), .SIGNED(0)) u3 (.clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(r3), .in_dir(in_dir), .in_data(d2),
      .out_valid(v3), .out_ready(out_ready), .out_dir(od3), .out_data(o3));

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Plain unsigned bubble sort as the reference.
   function automatic logic [255:0] ref_sort(input logic [255:0] d, input int n, input int w, input logic dir);
      logic [31:0] v[16];
      logic [31:0] t;
      logic [31:0] m;
      logic [255:0] r;
      m = (w == 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
      r = '0;
      for (int i = 0; i < n; i++) v[i] = 32'(d >> (i * w)) & m;
      for (int a = 0; a < n; a++)
         for (int b = 0; b < n - 1; b++)
            if (dir ? v[b] < v[b+1] : v[b] > v[b+1]) begin
               t = v[b];
               v[b] = v[b+1];
               v[b+1] = t;
            end
      for (int i = 0; i < n; i++) r = r | (256'(v[i]) << (i * w));
      return r;
   endfunction

   function automatic logic [255:0] rnd();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic fire(input logic dir, input logic [255:0] a, input logic [127:0] b, input logic [15:0] c);
      in_dir = dir; d8 = a; d16 = b; d2 = c; in_valid = 1;
      tick;
      in_valid = 0;
      lat0 = 0; lat2 = 0; lat3 = 0;
      for (int t = 1; t <= 14; t++) begin
         @(negedge clk);
         if (v0 && lat0 == 0) begin lat0 = t; c0 = o0; c1 = o1; cd0 = od0; end
         if (v2 && lat2 == 0) begin lat2 = t; c2 = o2; cd2 = od2; end
         if (v3 && lat3 == 0) begin lat3 = t; c3 = o3; cd3 = od3; end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic stream(input int n);
      logic acc;
      for (int i = 0; i < n; i++) begin
         in_valid = 1; in_dir = 1'(i % 2); d8 = rnd();
         acc = 0;
         for (int w = 0; w < 50 && !acc; w++) begin
            @(negedge clk);
            acc = r0;
            if (acc) sb_q.push_back({in_dir, d8});
            @(posedge clk);
            #1;
         end
         if (!acc) chk("accept_timeout", 256'd0, 256'd1);
      end
      in_valid = 0;
   endtask

   always @(negedge clk)
      if (sb_en && v0 && out_ready) begin
         if (sb_q.size() == 0) chk("extra_output", 256'd1, 256'd0);
         else begin
            logic [256:0] e;
            e = sb_q.pop_front();
            chk("stream_data", o0, ref_sort(e[255:0], 8, 32, e[256]));
            chk("stream_dir", 256'(od0), 256'(e[256]));
         end
      end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      logic [255:0] sv, hold;
      logic [127:0] r16;
      int seen;
      tick; tick;
      chk("rst_in_ready", 256'(r0), 256'd0);
      chk("rst_out_valid", 256'(v0), 256'd0);
      chk("rst_out_data", o0, 256'd0);
      rst = 0;
      tick;

      fire(0, {32'd4, 32'd6, 32'd2, 32'd7, 32'd1, 32'd8, 32'd3, 32'd5},
           {8'd77, 8'd5, 8'd180, 8'd7, 8'd42, 8'd99, 8'd1, 8'd64,
            8'd17, 8'd255, 8'd0, 8'd128, 8'd3, 8'd3, 8'd200, 8'd9},
           {8'h10, 8'h90});
      chk("lat8", 256'(lat0), 256'd6);
      chk("asc8", c0, {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
      chk("asc8_dir", 256'(cd0), 256'd0);
      chk("lat16", 256'(lat2), 256'd10);
      chk("asc16", 256'(c2), 256'({8'd255, 8'd200, 8'd180, 8'd128, 8'd99, 8'd77, 8'd64, 8'd42,
                                 8'd17, 8'd9, 8'd7, 8'd5, 8'd3, 8'd3, 8'd1, 8'd0}));
      chk("lat2", 256'(lat3), 256'd1);
      chk("asc2", 256'(c3), 256'({8'h90, 8'h10}));

      fire(1, {32'd4, 32'd6, 32'd2, 32'd7, 32'd1, 32'd8, 32'd3, 32'd5}, {16{8'h5A}}, {8'h10, 8'h90});
      chk("desc8", c0, {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8});
      chk("desc8_dir", 256'(cd0), 256'd1);
      chk("equal16", 256'(c2), 256'({16{8'h5A}}));
      chk("equal16_dir", 256'(cd2), 256'd1);
      chk("desc2", 256'(c3), 256'({8'h10, 8'h90}));
      chk("desc2_dir", 256'(cd3), 256'd1);

      sv = {32'd1, 32'd0, 32'd5, 32'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'hFFFF_FFFF};
      r16 = {$urandom, $urandom, $urandom, $urandom};
      fire(0, sv, r16, 16'h0);
      chk("signed8", c1, {32'h7FFF_FFFF, 32'd5, 32'd5, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000});
      chk("unsigned8", c0, {32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd5, 32'd5, 32'd1, 32'd0, 32'd0});
      chk("rand16_asc", 256'(c2), ref_sort(256'(r16), 16, 8, 0));
      r16 = {$urandom, $urandom, $urandom, $urandom};
      fire(1, rnd(), r16, 16'h0);
      chk("rand16_desc", 256'(c2), ref_sort(256'(r16), 16, 8, 1));

      sb_en = 1;
      stream(20);
      fork
         stream(10);
         begin
            for (int w = 0; w < 40 && !v0; w++) @(negedge clk);
            chk("stall_reached", 256'(v0), 256'd1);
            @(posedge clk);
            #1;
            out_ready = 0;
            @(negedge clk);
            hold = o0;
            for (int t = 0; t < 3; t++) begin
               chk("stall_in_ready", 256'(r0), 256'd0);
               chk("stall_valid", 256'(v0), 256'd1);
               chk("stall_hold", o0, hold);
               if (t < 2) @(negedge clk);
            end
            @(posedge clk);
            #1;
            out_ready = 1;
         end
      join
      for (int w = 0; w < 40 && sb_q.size() != 0; w++) tick;
      chk("drain", 256'(sb_q.size()), 256'd0);
      repeat (8) tick;
      sb_en = 0;

      for (int i = 0; i < 4; i++) begin
         in_valid = 1; in_dir = 1; d8 = rnd();
         tick;
      end
      in_valid = 0;
      rst = 1;
      #1;
      chk("midrst_in_ready", 256'(r0), 256'd0);
      tick;
      chk("midrst_valid", 256'(v0), 256'd0);
      chk("midrst_data", o0, 256'd0);
      chk("midrst_dir", 256'(od0), 256'd0);
      rst = 0;
      seen = 0;
      for (int t = 0; t < 12; t++) begin
         @(negedge clk);
         if (v0) seen++;
      end
      chk("midrst_ghost", 256'(seen), 256'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
